// File: rtl/ps2_keyboard_receiver_if.sv
// ps2_keyboard_receiver_if
//   Bundles the PS/2 pins, the CPU acknowledge and the KBDR/KBSR-facing
//   outputs of the keyboard receiver.
//   PS2_CLK, PS2_DAT     raw PS/2 clock/data from the connector (asynchronous)
//   Key_Ack              one-cycle pulse: CPU has consumed the held code
//   Data_ToKeyboardReg   {8'h00, held scan code}
//   Status               {Ready, Overrun, Parity_Err, Frame_Err, 12'h000}
//   Ready                held code valid, not yet acknowledged
//   master: drives the pins and Key_Ack; slave: the receiver itself.
interface ps2_keyboard_receiver_if;
  logic        PS2_CLK;
  logic        PS2_DAT;
  logic        Key_Ack;
  logic [15:0] Data_ToKeyboardReg;
  logic [15:0] Status;
  logic        Ready;

  modport master (
    output PS2_CLK, PS2_DAT, Key_Ack,
    input  Data_ToKeyboardReg, Status, Ready
  );

  modport slave (
    input  PS2_CLK, PS2_DAT, Key_Ack,
    output Data_ToKeyboardReg, Status, Ready
  );
endinterface

// File: rtl/ps2_keyboard_receiver.sv
// ps2_keyboard_receiver
//   Deserialises PS/2 device-to-host frames into 8-bit scan codes and holds
//   the latest one for the KBDR/KBSR registers, with parity, framing and
//   overrun flags cleared by a Key_Ack pulse.
//   Clk      system clock, all state on the rising edge
//   Reset_N  asynchronous active-low reset
//   bus      slave side of ps2_keyboard_receiver_if (pins, ack, outputs)
//
//   state  | meaning
//   IDLE   | waiting for a start bit (falling edge with data low)
//   DATA   | shifting in D0..D7, LSB first
//   PARITY | waiting for the odd-parity bit
//   STOP   | waiting for the stop bit; frame is evaluated on that edge
module ps2_keyboard_receiver #(
  parameter int SYNC_STAGES    = 2,
  parameter int FILTER_LEN     = 4,
  parameter int TIMEOUT_CYCLES = 5000
) (
  input  logic                      Clk,
  input  logic                      Reset_N,
  ps2_keyboard_receiver_if.slave    bus
);

  localparam int FCW = $clog2(FILTER_LEN + 1);
  localparam int TCW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

  logic [SYNC_STAGES-1:0] clk_sync_q, dat_sync_q;
  logic                   clk_s, dat_s;
  logic                   filt_q, fall_q;
  logic [FCW-1:0]         fcnt_q;

  state_t         state_q, state_d;
  logic [2:0]     bit_cnt_q, bit_cnt_d;
  logic [7:0]     shift_q, shift_d;
  logic           pbit_q, pbit_d;
  logic [TCW-1:0] tmo_q, tmo_d;
  logic [7:0]     data_q, data_d;
  logic           ready_q, ready_d;
  logic           ovr_q, ovr_d;
  logic           perr_q, perr_d;
  logic           ferr_q, ferr_d;
  logic           timeout_hit;

  // Synchronisers; bus idles high so reset to 1.
  always_ff @(posedge Clk or negedge Reset_N) begin
    if (!Reset_N) begin
      clk_sync_q <= '1;
      dat_sync_q <= '1;
    end else begin
      clk_sync_q <= {clk_sync_q[SYNC_STAGES-2:0], bus.PS2_CLK};
      dat_sync_q <= {dat_sync_q[SYNC_STAGES-2:0], bus.PS2_DAT};
    end
  end

  assign clk_s = clk_sync_q[SYNC_STAGES-1];
  assign dat_s = dat_sync_q[SYNC_STAGES-1];

  // Glitch filter: the filtered level follows clk_s only after FILTER_LEN
  // consecutive differing samples. fall_q is the registered 1->0 strobe.
  always_ff @(posedge Clk or negedge Reset_N) begin
    if (!Reset_N) begin
      filt_q <= 1'b1;
      fall_q <= 1'b0;
      fcnt_q <= '0;
    end else begin
      fall_q <= 1'b0;
      if (clk_s != filt_q) begin
        if (fcnt_q == FCW'(FILTER_LEN - 1)) begin
          filt_q <= clk_s;
          fcnt_q <= '0;
          fall_q <= filt_q;
        end else begin
          fcnt_q <= fcnt_q + 1'b1;
        end
      end else begin
        fcnt_q <= '0;
      end
    end
  end

  // A strobe in the same cycle restarts the timer, so it takes precedence.
  assign timeout_hit = (state_q != S_IDLE) && !fall_q &&
                       (tmo_q == TCW'(TIMEOUT_CYCLES - 1));

  // FSM: state register
  always_ff @(posedge Clk or negedge Reset_N) begin
    if (!Reset_N) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    if (timeout_hit) begin
      state_d = S_IDLE;
    end else if (fall_q) begin
      unique case (state_q)
        S_IDLE:   if (!dat_s) state_d = S_DATA;
        S_DATA:   if (bit_cnt_q == 3'd7) state_d = S_PARITY;
        S_PARITY: state_d = S_STOP;
        S_STOP:   state_d = S_IDLE;
        default:  state_d = S_IDLE;
      endcase
    end
  end

  // FSM: datapath / outputs
  always_comb begin
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    pbit_d    = pbit_q;
    data_d    = data_q;
    ready_d   = ready_q;
    ovr_d     = ovr_q;
    perr_d    = perr_q;
    ferr_d    = ferr_q;

    if (state_q == S_IDLE || fall_q)           tmo_d = '0;
    else if (tmo_q != TCW'(TIMEOUT_CYCLES - 1)) tmo_d = tmo_q + 1'b1;
    else                                       tmo_d = tmo_q;

    // Ack clears first; anything detected this cycle then overrides it.
    if (bus.Key_Ack) begin
      ready_d = 1'b0;
      ovr_d   = 1'b0;
      perr_d  = 1'b0;
      ferr_d  = 1'b0;
    end

    if (fall_q) begin
      unique case (state_q)
        S_IDLE:   bit_cnt_d = 3'd0;
        S_DATA: begin
          shift_d[bit_cnt_q] = dat_s;
          bit_cnt_d          = bit_cnt_q + 3'd1;
        end
        S_PARITY: pbit_d = dat_s;
        S_STOP: begin
          if (dat_s && (^{shift_q, pbit_q})) begin
            if (!ready_q || bus.Key_Ack) begin
              data_d  = shift_q;
              ready_d = 1'b1;
            end else begin
              ovr_d = 1'b1;
            end
          end else begin
            if (!(^{shift_q, pbit_q})) perr_d = 1'b1;
            if (!dat_s)                ferr_d = 1'b1;
          end
        end
        default: ;
      endcase
    end

    if (timeout_hit) ferr_d = 1'b1;
  end

  always_ff @(posedge Clk or negedge Reset_N) begin
    if (!Reset_N) begin
      bit_cnt_q <= '0;
      shift_q   <= '0;
      pbit_q    <= 1'b0;
      tmo_q     <= '0;
      data_q    <= '0;
      ready_q   <= 1'b0;
      ovr_q     <= 1'b0;
      perr_q    <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      pbit_q    <= pbit_d;
      tmo_q     <= tmo_d;
      data_q    <= data_d;
      ready_q   <= ready_d;
      ovr_q     <= ovr_d;
      perr_q    <= perr_d;
      ferr_q    <= ferr_d;
    end
  end

  assign bus.Data_ToKeyboardReg = {8'h00, data_q};
  assign bus.Status             = {ready_q, ovr_q, perr_q, ferr_q, 12'h000};
  assign bus.Ready              = ready_q;

endmodule

// File: tb/tb_ps2_keyboard_receiver.sv
module tb_ps2_keyboard_receiver;
  localparam int HALF = 20;
  localparam int TMO  = 5000;

  logic clk = 1'b0;
  logic rst_n;
  ps2_keyboard_receiver_if bus();

  ps2_keyboard_receiver #(
    .SYNC_STAGES(2),
    .FILTER_LEN(4),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .Clk(clk),
    .Reset_N(rst_n),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Frame-level reference model of the holding register and flags.
  logic [7:0] m_data;
  logic       m_rdy, m_ovr, m_perr, m_ferr;

  task automatic model_reset();
    m_data = 8'h00; m_rdy = 0; m_ovr = 0; m_perr = 0; m_ferr = 0;
  endtask

  task automatic model_ack();
    m_rdy = 0; m_ovr = 0; m_perr = 0; m_ferr = 0;
  endtask

  task automatic model_frame(input logic [7:0] code, input logic pbit,
                             input logic sbit, input bit ack);
    bit par_ok;
    par_ok = ($countones({code, pbit}) % 2) == 1;
    if (ack) model_ack();
    if (par_ok && sbit) begin
      if (!m_rdy) begin
        m_data = code;
        m_rdy  = 1;
      end else begin
        m_ovr = 1;
      end
    end else begin
      if (!par_ok) m_perr = 1;
      if (!sbit)   m_ferr = 1;
    end
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, " data"},   bus.Data_ToKeyboardReg, {8'h00, m_data});
    check({tag, " status"}, bus.Status, {m_rdy, m_ovr, m_perr, m_ferr, 12'h000});
    check({tag, " ready"},  {15'h0, bus.Ready}, {15'h0, m_rdy});
  endtask

  // One PS/2 bit; with ack set, Key_Ack lands in the cycle the receiver
  // sees this bit's falling-edge strobe (sync 2 + filter 4 cycles later).
  task automatic ps2_bit(input logic b, input bit ack);
    @(negedge clk) bus.PS2_DAT = b;
    repeat (HALF) @(negedge clk);
    bus.PS2_CLK = 1'b0;
    if (ack) begin
      repeat (6) @(negedge clk);
      bus.Key_Ack = 1'b1;
      @(negedge clk);
      bus.Key_Ack = 1'b0;
      repeat (HALF - 7) @(negedge clk);
    end else begin
      repeat (HALF) @(negedge clk);
    end
    bus.PS2_CLK = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] code, input logic pbit,
                            input logic sbit, input bit ack);
    ps2_bit(1'b0, 0);
    for (int i = 0; i < 8; i++) ps2_bit(code[i], 0);
    ps2_bit(pbit, 0);
    ps2_bit(sbit, ack);
    @(negedge clk) bus.PS2_DAT = 1'b1;
    repeat (HALF) @(negedge clk);
    model_frame(code, pbit, sbit, ack);
  endtask

  task automatic send_good(input logic [7:0] code, input bit ack);
    send_frame(code, ~^code, 1'b1, ack);
  endtask

  task automatic do_ack();
    @(negedge clk) bus.Key_Ack = 1'b1;
    @(negedge clk) bus.Key_Ack = 1'b0;
    repeat (2) @(negedge clk);
    model_ack();
  endtask

  initial begin
    logic [7:0] code;
    logic       pb, sb;
    bit         ack_stop;

    bus.PS2_CLK = 1'b1;
    bus.PS2_DAT = 1'b1;
    bus.Key_Ack = 1'b0;
    rst_n = 1'b0;
    model_reset();
    repeat (5) @(negedge clk);
    check_all("reset");
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // 1: reset in the middle of a frame, then re-align
    send_good(8'h77, 0);
    check_all("pre_reset");
    ps2_bit(1'b0, 0);
    ps2_bit(1'b1, 0);
    @(negedge clk) bus.PS2_DAT = 1'b0;
    bus.PS2_CLK = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all("mid_reset");
    @(negedge clk);
    bus.PS2_CLK = 1'b1;
    bus.PS2_DAT = 1'b1;
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    send_good(8'h1C, 0);
    check_all("realign_1C");

    // 2: receive and acknowledge
    do_ack();
    send_good(8'h5A, 0);
    check_all("rx_5A");
    do_ack();
    check_all("ack_5A");

    // 3: overrun
    send_good(8'h1C, 0);
    send_good(8'hF0, 0);
    check_all("overrun");
    do_ack();
    check_all("overrun_ack");

    // 4: parity error, then framing error
    send_frame(8'h1C, 1'b1, 1'b1, 0);
    check_all("parity_err");
    send_frame(8'h29, ~^8'h29, 1'b0, 0);
    check_all("frame_err");
    do_ack();

    // 5: timeout on a partial frame, then a clean frame
    ps2_bit(1'b0, 0);
    for (int i = 0; i < 4; i++) ps2_bit(1'b1, 0);
    @(negedge clk) bus.PS2_DAT = 1'b1;
    repeat (TMO + 50) @(negedge clk);
    m_ferr = 1;
    check_all("timeout");
    send_good(8'h32, 0);
    check_all("after_timeout_32");
    do_ack();

    // 6: clock glitch while idle, then ack coinciding with a good load
    send_good(8'h12, 0);
    check_all("rx_12");
    @(negedge clk) bus.PS2_DAT = 1'b0;
    bus.PS2_CLK = 1'b0;
    repeat (2) @(negedge clk);
    bus.PS2_CLK = 1'b1;
    repeat (10) @(negedge clk);
    bus.PS2_DAT = 1'b1;
    repeat (HALF) @(negedge clk);
    check_all("glitch");
    send_good(8'h45, 1);
    check_all("ack_load_45");

    // Randomised frames against the model
    for (int n = 0; n < 12; n++) begin
      code     = 8'($urandom);
      pb       = ~^code;
      sb       = 1'b1;
      if ($urandom_range(0, 3) == 0) pb = ~pb;
      if ($urandom_range(0, 3) == 0) sb = 1'b0;
      ack_stop = ($urandom_range(0, 3) == 0);
      send_frame(code, pb, sb, ack_stop);
      check_all($sformatf("rand%0d", n));
      if ($urandom_range(0, 2) == 0) begin
        do_ack();
        check_all($sformatf("rand%0d_ack", n));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
